// File: rtl/sample1_gen_pkg.sv
// sample1_gen_pkg
//   Shared definitions for the sample1_gen stimulus producer:
//   - DATA_W    : width of every data path (addresses, beat indices, counters)
//   - LFSR_POLY : Galois feedback mask used for the address sequence
//   - state_e   : producer FSM states (IDLE / BURST / GAP)
//   - lfsr_next : one Galois step of the address LFSR
package sample1_gen_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Right-shifting Galois form: the bit falling out of position 0 decides
  // whether the feedback mask is folded back in.
  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_POLY : {DATA_W{1'b0}});
  endfunction

endpackage

// File: rtl/sample1_gen_lfsr.sv
// sample1_gen_lfsr
//   32-bit Galois LFSR that steps only when asked to, so the address
//   sequence advances once per emitted beat rather than once per clock.
// Parameters:
//   SEED    : reset value, must be non-zero (an all-zero LFSR never leaves 0)
// Ports:
//   clk     in  : clock, posedge
//   reset_n in  : asynchronous active-low reset, loads SEED
//   advance in  : step the LFSR at the next posedge
//   value   out : current LFSR state
module sample1_gen_lfsr
  import sample1_gen_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              advance,
  output logic [DATA_W-1:0] value
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= SEED;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/sample1_gen.sv
// sample1_gen
//   Driving end of the two-module simulation example. Emits bursts of paired
//   address/data beats on to3_c/to3_d, separated by idle gaps, and folds the
//   returned to1_b stream into a rotating checksum.
// Parameters:
//   BURST_LEN : beats per burst (>= 1)
//   GAP_LEN   : idle cycles between bursts (>= 0, 0 gives back-to-back bursts)
//   SEED      : LFSR reset value, non-zero
// Ports:
//   clk        in  : clock, posedge
//   reset_n    in  : asynchronous active-low reset
//   start      in  : pulse, starts the burst sequence from IDLE
//   stop       in  : pulse, halts at the end of the current burst (or now, in a gap)
//   to3_cValid out : address beat valid
//   to3_c      out : address (current LFSR value)
//   to3_dValid out : data beat valid (always equal to to3_cValid)
//   to3_d      out : data (running beat index)
//   to1_b      in  : returned read data, sampled every cycle
//   busy       out : high whenever the FSM is not IDLE
//   sent_count out : total beats emitted since reset
//   checksum   out : rotating XOR signature of to1_b
// Build option:
//   SAMPLE1_GEN_CHECKSUM_EN : when defined the checksum is computed; otherwise
//   checksum is tied to zero and to1_b is ignored.
module sample1_gen
  import sample1_gen_pkg::*;
#(
  parameter int unsigned       BURST_LEN = 8,
  parameter int unsigned       GAP_LEN   = 3,
  parameter logic [DATA_W-1:0] SEED      = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  output logic              to3_cValid,
  output logic [DATA_W-1:0] to3_c,
  output logic              to3_dValid,
  output logic [DATA_W-1:0] to3_d,
  input  logic [DATA_W-1:0] to1_b,
  output logic              busy,
  output logic [DATA_W-1:0] sent_count,
  output logic [DATA_W-1:0] checksum
);

  state_e            state;
  logic [DATA_W-1:0] beat_cnt;
  logic [DATA_W-1:0] gap_cnt;
  logic              stop_pend;
  logic [DATA_W-1:0] lfsr_value;
  logic              emit;
  logic              burst_done;
  logic              gap_done;
  logic              stop_seen;

  sample1_gen_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .advance(emit),
    .value  (lfsr_value)
  );

  // Decide whether a beat is loaded into the output registers at the coming
  // edge. beat_cnt counts beats already shown in the current burst and
  // gap_cnt counts idle cycles already shown in the current gap, so "done"
  // means the cycle now on the outputs is the last one of that phase.
  // A stop arriving on the final beat is treated as pending for that burst.
  always_comb begin
    burst_done = (beat_cnt == BURST_LEN);
    gap_done   = (gap_cnt == GAP_LEN);
    stop_seen  = stop_pend || stop;
    emit       = 1'b0;
    unique case (state)
      IDLE:    emit = start;
      BURST:   emit = !burst_done || (!stop_seen && (GAP_LEN == 32'd0));
      GAP:     emit = !stop && gap_done;
      default: emit = 1'b0;
    endcase
  end

  // Producer FSM. busy is registered alongside the state so that it rises in
  // the same cycle as the first beat and falls with the return to IDLE.
  // With GAP_LEN of zero the GAP state is never entered and bursts chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      gap_cnt   <= '0;
      stop_pend <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= BURST;
            beat_cnt  <= 32'd1;
            stop_pend <= stop;
            busy      <= 1'b1;
          end
        end
        BURST: begin
          if (burst_done) begin
            if (stop_seen) begin
              state     <= IDLE;
              stop_pend <= 1'b0;
              busy      <= 1'b0;
            end else if (GAP_LEN == 32'd0) begin
              beat_cnt <= 32'd1;
            end else begin
              state   <= GAP;
              gap_cnt <= 32'd1;
            end
          end else begin
            beat_cnt <= beat_cnt + 32'd1;
            if (stop) begin
              stop_pend <= 1'b1;
            end
          end
        end
        GAP: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (gap_done) begin
            state    <= BURST;
            beat_cnt <= 32'd1;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        default: begin
          state     <= IDLE;
          stop_pend <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Beat output registers. The beat index and sent_count both start at zero
  // and clear only on reset, so the index of the beat being loaded is simply
  // the count before it is bumped. Between beats everything holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to3_cValid <= 1'b0;
      to3_dValid <= 1'b0;
      to3_c      <= '0;
      to3_d      <= '0;
      sent_count <= '0;
    end else begin
      to3_cValid <= emit;
      to3_dValid <= emit;
      if (emit) begin
        to3_c      <= lfsr_value;
        to3_d      <= sent_count;
        sent_count <= sent_count + 32'd1;
      end
    end
  end

  // Rotate-left-and-XOR signature of the returned stream, independent of
  // the FSM so that every cycle of to1_b contributes.
`ifdef SAMPLE1_GEN_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else begin
      checksum <= {checksum[DATA_W-2:0], checksum[DATA_W-1]} ^ to1_b;
    end
  end
`else
  logic unused_to1_b;

  assign checksum     = '0;
  assign unused_to1_b = ^to1_b;
`endif

endmodule

// File: tb/tb_sample1_gen.sv
// tb_sample1_gen
//   Drives two sample1_gen instances from shared stimulus: one with
//   BURST_LEN=4/GAP_LEN=2 and one with BURST_LEN=2/GAP_LEN=0 (back-to-back
//   bursts). A behavioural model tracks each instance by its position inside
//   the burst+gap period and is compared against every output on every
//   falling edge. Directed sequences pin the model with literal values,
//   then a randomized phase exercises start/stop/to1_b.
module tb_sample1_gen;

  localparam int          NI   = 2;
  localparam int unsigned B0   = 4;
  localparam int unsigned G0   = 2;
  localparam int unsigned B1   = 2;
  localparam int unsigned G1   = 0;
  localparam logic [31:0] S0   = 32'h0000_0001;
  localparam logic [31:0] S1   = 32'hACE1_0001;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        stop    = 1'b0;
  logic [31:0] to1_b   = '0;

  logic [NI-1:0] cv;
  logic [NI-1:0] dv;
  logic [NI-1:0] bsy;
  logic [31:0]   c    [NI];
  logic [31:0]   d    [NI];
  logic [31:0]   sent [NI];
  logic [31:0]   cs   [NI];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state per instance: running flag, position within the period
  // (0..BL-1 are beats, BL..BL+GL-1 are gap cycles), pending stop,
  // and the expected output values.
  int unsigned bl [NI] = '{B0, B1};
  int unsigned gl [NI] = '{G0, G1};
  logic [31:0] sd [NI] = '{S0, S1};
  bit          m_run   [NI];
  int unsigned m_pos   [NI];
  bit          m_pend  [NI];
  bit          m_valid [NI];
  logic [31:0] m_lfsr  [NI];
  logic [31:0] m_beats [NI];
  logic [31:0] m_c     [NI];
  logic [31:0] m_d     [NI];
  logic [31:0] m_sent  [NI];
  logic [31:0] m_cs    [NI];

  always #5 clk = ~clk;

  sample1_gen #(.BURST_LEN(B0), .GAP_LEN(G0), .SEED(S0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .to3_cValid(cv[0]), .to3_c(c[0]), .to3_dValid(dv[0]), .to3_d(d[0]),
    .to1_b(to1_b), .busy(bsy[0]), .sent_count(sent[0]), .checksum(cs[0])
  );

  sample1_gen #(.BURST_LEN(B1), .GAP_LEN(G1), .SEED(S1)) dut_b2g0 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .to3_cValid(cv[1]), .to3_c(c[1]), .to3_dValid(dv[1]), .to3_d(d[1]),
    .to1_b(to1_b), .busy(bsy[1]), .sent_count(sent[1]), .checksum(cs[1])
  );

  function automatic logic [31:0] galois(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? POLY : 32'h0);
  endfunction

  task automatic model_reset(input int i);
    m_run[i]   = 1'b0;
    m_pos[i]   = 0;
    m_pend[i]  = 1'b0;
    m_valid[i] = 1'b0;
    m_lfsr[i]  = sd[i];
    m_beats[i] = '0;
    m_c[i]     = '0;
    m_d[i]     = '0;
    m_sent[i]  = '0;
    m_cs[i]    = '0;
  endtask

  task automatic model_step(input int i);
    bit em;
    em = 1'b0;
    if (!m_run[i]) begin
      if (start) begin
        m_run[i]  = 1'b1;
        m_pos[i]  = 0;
        m_pend[i] = stop;
        em        = 1'b1;
      end
    end else if (m_pos[i] < bl[i]) begin
      m_pend[i] = m_pend[i] | stop;
      if (m_pos[i] == bl[i] - 1) begin
        if (m_pend[i]) begin
          m_run[i]  = 1'b0;
          m_pend[i] = 1'b0;
        end else if (gl[i] == 0) begin
          m_pos[i] = 0;
          em       = 1'b1;
        end else begin
          m_pos[i] = bl[i];
        end
      end else begin
        m_pos[i] = m_pos[i] + 1;
        em       = 1'b1;
      end
    end else begin
      if (stop) begin
        m_run[i] = 1'b0;
      end else if (m_pos[i] == bl[i] + gl[i] - 1) begin
        m_pos[i] = 0;
        em       = 1'b1;
      end else begin
        m_pos[i] = m_pos[i] + 1;
      end
    end
    m_valid[i] = em;
    if (em) begin
      m_c[i]     = m_lfsr[i];
      m_lfsr[i]  = galois(m_lfsr[i]);
      m_d[i]     = m_beats[i];
      m_beats[i] = m_beats[i] + 1;
      m_sent[i]  = m_beats[i];
    end
`ifdef SAMPLE1_GEN_CHECKSUM_EN
    m_cs[i] = {m_cs[i][30:0], m_cs[i][31]} ^ to1_b;
`endif
  endtask

  // Model advances on each rising edge and clears immediately on reset.
  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset_n) model_reset(i);
      else          model_step(i);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge and are held for exactly one rising edge.
  task automatic applyStimulus(input bit st, input bit sp);
    start = st;
    stop  = sp;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        checkOutput($sformatf("cValid%0d", i), 32'(cv[i]), 32'(m_valid[i]));
        checkOutput($sformatf("dValid%0d", i), 32'(dv[i]), 32'(m_valid[i]));
        checkOutput($sformatf("to3_c%0d", i), c[i], m_c[i]);
        checkOutput($sformatf("to3_d%0d", i), d[i], m_d[i]);
        checkOutput($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m_run[i]));
        checkOutput($sformatf("sent%0d", i), sent[i], m_sent[i]);
        checkOutput($sformatf("checksum%0d", i), cs[i], m_cs[i]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0]  vpat;
    logic [9:0]  vpat_b;
    logic [31:0] dd [1:10];
    logic [31:0] cc [1:10];
    logic [31:0] db [1:10];
    logic [31:0] cb [1:10];
    logic [31:0] cs_exp [3];
    logic [31:0] sent_before;
    int          nbeats;

    for (int i = 0; i < NI; i++) model_reset(i);

    // Checksum after reset with to1_b held at 1.
`ifdef SAMPLE1_GEN_CHECKSUM_EN
    cs_exp = '{32'd1, 32'd3, 32'd7};
`else
    cs_exp = '{32'd0, 32'd0, 32'd0};
`endif
    to1_b = 32'd1;
    repeat (2) @(negedge clk);
    chk_en  = 1'b1;
    checkOutput("reset_busy", 32'(bsy[0]), 32'd0);
    checkOutput("reset_sent", sent[0], 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("checksum_lit%0d", k), cs[0], cs_exp[k]);
    end
    to1_b = 32'd0;

    // Stop during a burst: the burst still completes all four beats.
    applyStimulus(1'b1, 1'b0);
    checkOutput("first_beat_d", d[0], 32'd0);
    checkOutput("first_beat_c", c[0], S0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("stop_last_valid", 32'(cv[0]), 32'd1);
    checkOutput("stop_last_d", d[0], 32'd3);
    @(negedge clk);
    checkOutput("stop_idle_busy", 32'(bsy[0]), 32'd0);
    checkOutput("stop_idle_valid", 32'(cv[0]), 32'd0);
    checkOutput("stop_sent", sent[0], 32'd4);

    // Restart resumes the beat index.
    applyStimulus(1'b1, 1'b0);
    checkOutput("resume_d", d[0], 32'd4);
    checkOutput("resume_valid", 32'(cv[0]), 32'd1);

    // Asynchronous reset in the third beat clears everything at once.
    @(negedge clk);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("arst_cValid", 32'(cv[0]), 32'd0);
    checkOutput("arst_dValid", 32'(dv[0]), 32'd0);
    checkOutput("arst_c", c[0], 32'd0);
    checkOutput("arst_d", d[0], 32'd0);
    checkOutput("arst_busy", 32'(bsy[0]), 32'd0);
    checkOutput("arst_sent", sent[0], 32'd0);
    checkOutput("arst_checksum", cs[0], 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Fresh start: record ten cycles of both instances.
    applyStimulus(1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      vpat[10-k]   = cv[0];
      vpat_b[10-k] = cv[1];
      dd[k] = d[0];
      cc[k] = c[0];
      db[k] = d[1];
      cb[k] = c[1];
      if (k < 10) @(negedge clk);
    end
    checkOutput("pattern_b4g2", 32'(vpat), 32'h0000_03CF);
    for (int k = 1; k <= 4; k++) begin
      checkOutput($sformatf("burst1_d%0d", k), dd[k], 32'(k - 1));
      checkOutput($sformatf("burst2_d%0d", k), dd[k + 6], 32'(k + 3));
    end
    checkOutput("gap_hold_d", dd[6], 32'd3);
    checkOutput("c_beat0", cc[1], 32'h0000_0001);
    checkOutput("c_beat1", cc[2], 32'h8020_0003);
    checkOutput("pattern_b2g0", 32'(vpat_b), 32'h0000_03FF);
    for (int k = 1; k <= 10; k++) begin
      checkOutput($sformatf("b2g0_d%0d", k), db[k], 32'(k - 1));
    end
    checkOutput("b2g0_c0", cb[1], S1);
    checkOutput("b2g0_c1", cb[2], 32'hD650_8003);

    // Stop and wait for both instances to go idle.
    applyStimulus(1'b0, 1'b1);
    for (int n = 0; n < 50; n++) begin
      if (bsy == '0) break;
      @(negedge clk);
    end
    checkOutput("idle_wait", 32'(bsy), 32'd0);

    // start+stop together from IDLE gives exactly one burst; a start pulsed
    // mid-burst changes nothing.
    sent_before = sent[0];
    applyStimulus(1'b1, 1'b1);
    nbeats = 0;
    for (int n = 0; n < 40; n++) begin
      if (cv[0]) nbeats++;
      if (!bsy[0]) break;
      start = (n == 1);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("one_burst_beats", 32'(nbeats), 32'd4);
    checkOutput("one_burst_sent", sent[0] - sent_before, 32'd4);
    checkOutput("one_burst_idle", 32'(bsy[0]), 32'd0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      to1_b = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample1_gen.md
# sample1_gen

Stimulus/producer block for the sample3 write port in the simlib Verilator examples. Emits bursts of paired address/data beats on the `to3_c`/`to3_d` valid-qualified interface and consumes the returned `to1_b` read stream into a running checksum. Used as the driving end of the two-module simulation example, so that multi-module simulation can run without a C++ testbench.

## Interface
- `BURST_LEN`, 8: beats per burst, ≥1.
- `GAP_LEN`, 3: idle cycles between bursts, ≥0.
- `SEED`, 32'h0000_0001: LFSR reset value, must be non-zero.
- `clk` in 1: single clock, all logic on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse; begins burst sequence when idle.
- `stop` in 1: pulse; requests halt at end of current burst.
- `to3_cValid` out 1: address beat valid.
- `to3_c` out 32: address value.
- `to3_dValid` out 1: data beat valid.
- `to3_d` out 32: data value.
- `to1_b` in 32: read data returned from consumer.
- `busy` out 1: high in any state other than IDLE.
- `sent_count` out 32: total beats emitted.
- `checksum` out 32: running signature of `to1_b`.

## Operation
- FSM states: IDLE, BURST, GAP.
- IDLE: on `start`, go to BURST. `start` in other states is ignored.
- BURST: one beat per cycle; both valids high together, never split. After `BURST_LEN` beats: GAP if `GAP_LEN`>0, else BURST directly. If a stop is pending, go to IDLE instead.
- GAP: valids low for `GAP_LEN` cycles, then BURST.
- `stop` sets a sticky pending flag. The flag is consumed at the end of the current burst. In GAP, `stop` exits to IDLE on the next cycle. In IDLE, `stop` is ignored. `start`+`stop` in the same cycle from IDLE: the start wins, and stop is pending.
- `to3_c` = current LFSR value. The LFSR is 32-bit Galois, poly 32'h8020_0003: next = (x>>1) ^ (x[0] ? POLY : 0). It advances once per emitted beat only.
- `to3_d` = beat index from 0, wraps at 2^32. It persists across bursts and stop/start and clears only on reset.
- `sent_count` increments per beat and wraps mod 2^32.
- `checksum` <= {checksum[30:0], checksum[31]} ^ `to1_b` every cycle while out of reset, regardless of FSM state.

## Timing
- All outputs are registered.
- Reset values: valids 0, `to3_c`=0, `to3_d`=0, `busy`=0, `sent_count`=0, `checksum`=0. Internal LFSR=`SEED`, state IDLE, pending stop cleared.
- `start` sampled at edge N: first beat valid in cycle N+1, with `to3_c`=`SEED` and `to3_d`=0. `busy` is high from N+1.
- Between beats, outputs hold their last values with valids low.
- `reset_n` falling mid-burst clears everything asynchronously. The beat in flight is dropped.
- `reset_n` deassertion takes effect at the next posedge, with no synchronizer inside the block.
- `to1_b` is sampled every posedge; no valid qualifier.

## Configuration
- `SAMPLE1_GEN_CHECKSUM_EN` defined: checksum logic is present as above.
- Not defined: `checksum` is tied to 0 and `to1_b` is unused. All other behaviour is identical.

## Structure
- Package `sample1_gen_pkg`:
  - state enum (IDLE/BURST/GAP);
  - `LFSR_POLY` = 32'h8020_0003;
  - data width constant 32.
- Sub-module `sample1_gen_lfsr`: inputs `clk`, `reset_n`, `advance`; parameter `SEED`; output `value`.
- FSM, counters and checksum stay in the top module.

## Test plan
- BURST_LEN=4, GAP_LEN=2, start at cycle 0:
  - valids high cycles 1–4, low 5–6, high 7–10;
  - `to3_d` = 0,1,2,3 then 4,5,6,7;
  - `to3_c` = 1 then 32'h8020_0003.
- Stop:
  - `stop` pulsed in cycle 2 of a burst: burst completes all 4 beats, then IDLE with `busy`=0 and `sent_count`=4;
  - a second `start` resumes with `to3_d`=4.
- With `SAMPLE1_GEN_CHECKSUM_EN`: `to1_b`=1 held 3 cycles after reset gives `checksum` 1, 3, 7.
- `reset_n` asserted in the 3rd beat of a burst: all outputs are 0 immediately. After release plus `start`, `to3_c`=`SEED` and `to3_d`=0.
- GAP_LEN=0, BURST_LEN=2: valids continuously high across the burst boundary; LFSR and `to3_d` advance every cycle.
- `start` pulsed while busy: no effect on sequence or counts. `start` and `stop` together from IDLE: exactly one burst is emitted.
